// File: rtl/dice_roll_sampler.sv
// dice_roll_sampler: assembles serial LFSR bits into draws and rejection-samples a uniform die face.
module dice_roll_sampler #(
  parameter int NUM_SIDES = 6,
  parameter int MAX_REJECT = 15,
  localparam int VW = $clog2(NUM_SIDES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rnd_bit,
  input  logic          rnd_tick,
  input  logic          roll,
  output logic [VW-1:0] value,
  output logic [6:0]    seg,
  output logic          busy,
  output logic          done,
  output logic [3:0]    reject_cnt
);
  localparam int W = $clog2(NUM_SIDES);
  typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;
  state_t state_q, state_d;
  logic [W-1:0] sr_q, sr_d;
  logic [1:0] cnt_q, cnt_d;
  logic [VW-1:0] value_q, value_d;
  logic [6:0] seg_q, seg_d;
  logic done_q, done_d;
  logic [3:0] rej_q, rej_d, rej_inc, face;
  logic roll_q, roll_rise, accept, fallback;
  function automatic logic [6:0] decode(input logic [3:0] f);
    case (f)
      4'd1: decode = 7'h06;
      4'd2: decode = 7'h5B;
      4'd3: decode = 7'h4F;
      4'd4: decode = 7'h66;
      4'd5: decode = 7'h6D;
      4'd6: decode = 7'h7D;
      4'd7: decode = 7'h07;
      4'd8: decode = 7'h7F;
      default: decode = 7'h00;
    endcase
  endfunction
  always_comb begin
    roll_rise = roll & ~roll_q;
    rej_inc = (rej_q == 4'd15) ? rej_q : rej_q + 4'd1;
    accept = 32'(sr_q) < NUM_SIDES;
    fallback = !accept && rej_inc == 4'(MAX_REJECT);
    face = accept ? 4'(sr_q) + 4'd1 : 4'(sr_q) - 4'(NUM_SIDES) + 4'd1;
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    value_d = value_q;
    seg_d = seg_q;
    done_d = 1'b0;
    rej_d = rej_q;
    case (state_q)
      IDLE: if (roll_rise) begin
        state_d = COLLECT;
        cnt_d = '0;
        rej_d = '0;
      end
      COLLECT: if (rnd_tick) begin
        sr_d = W'({sr_q, rnd_bit});
        cnt_d = cnt_q + 2'd1;
        state_d = (cnt_q == 2'(W - 1)) ? CHECK : COLLECT;
      end
      CHECK: begin
        rej_d = accept ? rej_q : rej_inc;
        if (accept || fallback) begin
          value_d = VW'(face);
          seg_d = decode(face);
          done_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      value_q <= '0;
      seg_q <= '0;
      done_q <= 1'b0;
      rej_q <= '0;
      roll_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      value_q <= value_d;
      seg_q <= seg_d;
      done_q <= done_d;
      rej_q <= rej_d;
      roll_q <= roll;
    end
  end
  assign value = value_q;
  assign seg = seg_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign reject_cnt = rej_q;
endmodule

// File: tb/tb_dice_roll_sampler.sv
// tb_dice_roll_sampler: scoreboard bench for a 6-sided and an 8-sided sampler sharing one bit stream.
module tb_dice_roll_sampler;
  logic clk = 0, rst = 1, rnd_bit = 0, rnd_tick = 0, roll = 1, roll8 = 0;
  logic [2:0] value;
  logic [3:0] value8, reject_cnt, rej8;
  logic [6:0] seg, seg8;
  logic busy, done, busy8, done8;
  int n_chk = 0, n_fail = 0;
  typedef struct {int v; int s; int r;} exp_t;
  exp_t q6[$], q8[$];
  exp_t e6, e8;
  always #5 clk = ~clk;
  dice_roll_sampler #(.NUM_SIDES(6)) dut (
    .clk(clk), .rst(rst), .rnd_bit(rnd_bit), .rnd_tick(rnd_tick), .roll(roll),
    .value(value), .seg(seg), .busy(busy), .done(done), .reject_cnt(reject_cnt));
  dice_roll_sampler #(.NUM_SIDES(8)) dut8 (
    .clk(clk), .rst(rst), .rnd_bit(rnd_bit), .rnd_tick(rnd_tick), .roll(roll8),
    .value(value8), .seg(seg8), .busy(busy8), .done(done8), .reject_cnt(rej8));
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic b);
    rnd_bit = b;
    rnd_tick = 1;
    cyc(1);
    rnd_tick = 0;
    rnd_bit = 0;
    cyc(3);
  endtask
  task automatic draw(input int v);
    send(v[2]);
    send(v[1]);
    send(v[0]);
  endtask
  task automatic press;
    roll = 1;
    cyc(1);
    roll = 0;
    cyc(1);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_value"}, value, 0);
    chk({tag, "_seg"}, seg, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rej"}, reject_cnt, 0);
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (q6.size() == 0) chk("unexpected_done6", done, 0);
      else begin
        e6 = q6.pop_front();
        chk("value6", value, e6.v);
        chk("seg6", seg, e6.s);
        chk("rej6", reject_cnt, e6.r);
        chk("busy_at_done6", busy, 0);
      end
    end
    if (done8) begin
      if (q8.size() == 0) chk("unexpected_done8", done8, 0);
      else begin
        e8 = q8.pop_front();
        chk("value8", value8, e8.v);
        chk("seg8", seg8, e8.s);
        chk("rej8", rej8, e8.r);
        chk("busy_at_done8", busy8, 0);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    cyc(2);
    chk_reset("in_reset");
    rst = 0;
    cyc(1);
    chk_reset("after_reset");
    send(1); send(1); send(1);
    chk("held_roll_busy", busy, 0);
    roll = 0;
    cyc(2);
    press;
    chk("busy_collect", busy, 1);
    q6.push_back('{4, 'h66, 0});
    draw(3);
    cyc(2);
    chk("busy_after_basic", busy, 0);
    press;
    q6.push_back('{1, 'h06, 1});
    draw(7);
    draw(0);
    cyc(2);
    press;
    q6.push_back('{1, 'h06, 15});
    repeat (15) draw(6);
    cyc(2);
    press;
    q6.push_back('{5, 'h6D, 0});
    send(1);
    roll = 1; cyc(1); roll = 0; cyc(1);
    roll = 1; cyc(1); roll = 0; cyc(1);
    send(0);
    send(0);
    cyc(4);
    roll = 1; rnd_bit = 1; rnd_tick = 1;
    cyc(1);
    roll = 0; rnd_tick = 0; rnd_bit = 0;
    cyc(1);
    q6.push_back('{3, 'h4F, 0});
    send(0);
    send(1);
    rnd_bit = 0; rnd_tick = 1;
    cyc(1);
    rnd_bit = 1;
    cyc(1);
    rnd_tick = 0; rnd_bit = 0;
    cyc(4);
    press;
    send(1);
    send(1);
    rst = 1;
    cyc(1);
    chk_reset("mid_roll_reset");
    rst = 0;
    cyc(2);
    press;
    q6.push_back('{6, 'h7D, 0});
    draw(5);
    cyc(2);
    roll8 = 1; cyc(1); roll8 = 0; cyc(1);
    q8.push_back('{8, 'h7F, 0});
    draw(7);
    cyc(5);
    chk("q6_drained", q6.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
